// File: rtl/print_arb_pkg.sv
// Shared types for the debug print arbiter: FSM states, data width and the
// pointer-width helper used by the arbiter and its round-robin picker.
package print_arb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width of a requester index; never below one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/print_arb_if.sv
// Bundle of requester-side and PRINT-side signals around print_arb.
// slave = arbiter view, master = requesters plus PRINT view.
interface print_arb_if
  import print_arb_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]        req_i;
  logic [N_REQ-1:0]        type_i;
  logic [DATA_W*N_REQ-1:0] dout_i;
  logic [N_REQ-1:0]        ack_o;
  logic [N_REQ-1:0]        gnt_o;
  logic                    busy_o;
  logic                    req_tx;
  logic                    type_tx;
  logic [DATA_W-1:0]       dout_tx;
  logic                    ack_tx;
  logic                    tmo_o;

  modport slave (
    input  req_i, type_i, dout_i, ack_tx,
    output ack_o, gnt_o, busy_o, req_tx, type_tx, dout_tx, tmo_o
  );

  modport master (
    output req_i, type_i, dout_i, ack_tx,
    input  ack_o, gnt_o, busy_o, req_tx, type_tx, dout_tx, tmo_o
  );

endinterface

// File: rtl/print_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping mod N. Returns one-hot grant and its index.
module rr_pick
  import print_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic found;
  int   k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = PW'(k);
      end
    end
  end

endmodule

// File: rtl/print_arb.sv
// Round-robin arbiter sharing one PRINT/UART path between debug requesters.
// Optional WAIT watchdog enabled by defining PRINT_ARB_TIMEOUT_EN.
module print_arb
  import print_arb_pkg::*;
#(
  parameter int          N_REQ       = 4,
  parameter logic [31:0] TIMEOUT_CYC = 32'd2_000_000
) (
  input logic        clk,
  input logic        rst,
  print_arb_if.slave bus
);

  localparam int PW = ptr_w(N_REQ);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               type_q, type_d;
  logic               req_tx_q, req_tx_d;
  logic               busy_q, busy_d;
  logic               tmo_q, tmo_d;
  logic               tmo_hit;

  logic [N_REQ-1:0]   pick_gnt;
  logic [PW-1:0]      pick_idx;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req (bus.req_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Explicit wrap so non-power-of-two N_REQ never lands on an unused index.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] w);
    return (int'(w) == N_REQ - 1) ? '0 : w + 1'b1;
  endfunction

`ifdef PRINT_ARB_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;

  // cnt_q counts completed WAIT cycles; the last one fires the watchdog.
  assign tmo_hit = (cnt_q == TIMEOUT_CYC - 32'd1);
  assign cnt_d   = (state_q == WAIT) ? cnt_q + 32'd1 : '0;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    dout_d   = dout_q;
    type_d   = type_q;
    ack_d    = '0;
    req_tx_d = 1'b0;
    tmo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req_i) begin
          state_d  = ISSUE;
          gnt_d    = pick_gnt;
          idx_d    = pick_idx;
          dout_d   = bus.dout_i[int'(pick_idx)*DATA_W +: DATA_W];
          type_d   = bus.type_i[pick_idx];
          req_tx_d = 1'b1;
        end
      end
      ISSUE: begin
        if (bus.ack_tx) begin
          state_d = DONE;
          ack_d   = gnt_q;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.ack_tx) begin
          state_d = DONE;
          ack_d   = gnt_q;
        end else if (tmo_hit) begin
          // Watchdog skips DONE: acknowledge, release and rotate in one step.
          state_d = IDLE;
          ack_d   = gnt_q;
          tmo_d   = 1'b1;
          gnt_d   = '0;
          ptr_d   = ptr_next(idx_q);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = ptr_next(idx_q);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      dout_q   <= '0;
      type_q   <= 1'b0;
      ack_q    <= '0;
      req_tx_q <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      dout_q   <= dout_d;
      type_q   <= type_d;
      ack_q    <= ack_d;
      req_tx_q <= req_tx_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.gnt_o   = gnt_q;
  assign bus.busy_o  = busy_q;
  assign bus.req_tx  = req_tx_q;
  assign bus.type_tx = type_q;
  assign bus.dout_tx = dout_q;
  assign bus.tmo_o   = tmo_q;

endmodule
